// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: steps each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath enables, the writeback mux select and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int unsigned RET_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             addr_sel,
  output logic             mem_we,
  output logic             reg_we,
  output logic [2:0]       wb_sel,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_EXEC_R     = 5'd4,
    S_EXEC_I     = 5'd5,
    S_ALU_WB     = 5'd6,
    S_MEM_ADDR   = 5'd7,
    S_MEM_READ   = 5'd8,
    S_MEM_WB     = 5'd9,
    S_MEM_WRITE  = 5'd10,
    S_BRANCH     = 5'd11,
    S_JAL        = 5'd12,
    S_JALR       = 5'd13,
    S_LUI        = 5'd14,
    S_AUIPC      = 5'd15,
    S_NOP_RET    = 5'd16,
    S_HALT       = 5'd17
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [RET_W-1:0] retired_q;
  logic             reg_we_raw;
  logic [6:0]       opcode;
  logic             rd_zero;
  logic             unused_instr_bits;

  assign opcode            = instr[6:0];
  assign rd_zero           = (instr[11:7] == 5'd0);
  assign unused_instr_bits = ^instr[31:12];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (pc_we) begin
        retired_q <= retired_q + RET_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RESET:      state_d = S_FETCH;
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_IMM:             state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_AUIPC;
          OP_SYSTEM:          state_d = S_HALT;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end else begin
              state_d = S_NOP_RET;
            end
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADDR:         state_d = instr[5] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:         state_d = S_MEM_WB;
      S_ALU_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH,
      S_JAL, S_JALR, S_LUI, S_AUIPC, S_NOP_RET:
                          state_d = S_FETCH;
      S_HALT:             state_d = S_HALT;
      default:            state_d = S_RESET;
    endcase
  end

  // Moore decode; the only input-dependent output is pc_sel in BRANCH.
  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    addr_sel   = 1'b0;
    mem_we     = 1'b0;
    reg_we_raw = 1'b0;
    wb_sel     = 3'b000;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH_WAIT: ir_we = 1'b1;
      S_EXEC_R: alu_op = 2'b10;
      S_EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        reg_we_raw = 1'b1;
        pc_we      = 1'b1;
      end
      S_MEM_ADDR: alu_src_b = 1'b1;
      S_MEM_READ: addr_sel = 1'b1;
      S_MEM_WB: begin
        reg_we_raw = 1'b1;
        wb_sel     = 3'b001;
        pc_we      = 1'b1;
      end
      S_MEM_WRITE: begin
        addr_sel = 1'b1;
        mem_we   = 1'b1;
        pc_we    = 1'b1;
      end
      S_BRANCH: begin
        alu_op = 2'b01;
        pc_we  = 1'b1;
        pc_sel = branch_taken ? 2'd1 : 2'd0;
      end
      S_JAL: begin
        reg_we_raw = 1'b1;
        wb_sel     = 3'b010;
        pc_we      = 1'b1;
        pc_sel     = 2'd1;
      end
      S_JALR: begin
        alu_src_b  = 1'b1;
        reg_we_raw = 1'b1;
        wb_sel     = 3'b010;
        pc_we      = 1'b1;
        pc_sel     = 2'd2;
      end
      S_LUI: begin
        reg_we_raw = 1'b1;
        wb_sel     = 3'b011;
        pc_we      = 1'b1;
      end
      S_AUIPC: begin
        reg_we_raw = 1'b1;
        wb_sel     = 3'b100;
        pc_we      = 1'b1;
      end
      S_NOP_RET: pc_we = 1'b1;
      S_HALT: begin
        halted  = 1'b1;
        illegal = illegal_q;
      end
      default: ;
    endcase
  end

  // Writes to x0 are suppressed here so the register file needs no special case.
  assign reg_we  = reg_we_raw & ~rd_zero;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a default instance plus a 2-bit-counter,
// NOP-on-illegal instance driven in lockstep to exercise counter wrap and NOP_RET.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] instr;
  logic        branch_taken;

  logic        ir_we, pc_we, addr_sel, mem_we, reg_we, alu_src_b, halted, illegal;
  logic [1:0]  pc_sel, alu_op;
  logic [2:0]  wb_sel;
  logic [31:0] retired;

  logic        ir_we2, pc_we2, addr_sel2, mem_we2, reg_we2, alu_src_b2, halted2, illegal2;
  logic [1:0]  pc_sel2, alu_op2;
  logic [2:0]  wb_sel2;
  logic [1:0]  retired2;

  int          total = 0;
  int          bad   = 0;
  int unsigned exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.RET_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .resetn(resetn), .instr(instr), .branch_taken(branch_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .addr_sel(addr_sel),
    .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .halted(halted), .illegal(illegal), .retired(retired)
  );

  multicycle_control_fsm #(.RET_W(2), .HALT_ON_ILLEGAL(1'b0)) dut2 (
    .clk(clk), .resetn(resetn), .instr(instr), .branch_taken(branch_taken),
    .ir_we(ir_we2), .pc_we(pc_we2), .pc_sel(pc_sel2), .addr_sel(addr_sel2),
    .mem_we(mem_we2), .reg_we(reg_we2), .wb_sel(wb_sel2), .alu_src_b(alu_src_b2),
    .alu_op(alu_op2), .halted(halted2), .illegal(illegal2), .retired(retired2)
  );

  logic [14:0] outv, outv2;
  assign outv  = {ir_we, pc_we, pc_sel, addr_sel, mem_we, reg_we, wb_sel,
                  alu_src_b, alu_op, halted, illegal};
  assign outv2 = {ir_we2, pc_we2, pc_sel2, addr_sel2, mem_we2, reg_we2, wb_sel2,
                  alu_src_b2, alu_op2, halted2, illegal2};

  // Expected output vector: ir_we, pc_we, pc_sel, addr_sel, mem_we, reg_we, wb_sel, alu_src_b, alu_op, halted, illegal
  function automatic logic [14:0] o(input logic ir, input logic pc, input logic [1:0] pcs,
                                    input logic as, input logic mw, input logic rw,
                                    input logic [2:0] wb, input logic bs, input logic [1:0] aop,
                                    input logic h, input logic il);
    return {ir, pc, pcs, as, mw, rw, wb, bs, aop, h, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [14:0] e);
    chk({tag, " d1"}, 32'(outv), 32'(e));
    chk({tag, " d2"}, 32'(outv2), 32'(e));
    tick();
  endtask

  task automatic front(input string tag, input logic [31:0] ins);
    instr = ins;
    step({tag, " fetch"}, '0);
    step({tag, " fwait"}, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step({tag, " decode"}, '0);
  endtask

  task automatic chk_ret(input string tag);
    chk({tag, " retired"}, retired, 32'(exp_ret));
    chk({tag, " retired2"}, 32'(retired2), 32'(exp_ret % 4));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    chk("reset outs", 32'(outv), 32'd0);
    chk("reset outs2", 32'(outv2), 32'd0);
    exp_ret = 0;
    chk_ret("reset");
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn       = 1'b0;
    instr        = 32'h0;
    branch_taken = 1'b0;
    repeat (3) tick();
    chk("rst hold outs", 32'(outv), 32'd0);
    chk_ret("rst hold");
    resetn = 1'b1;
    chk("s_reset outs", 32'(outv), 32'd0);
    tick();

    front("add", 32'h002081B3);
    step("add exec", o(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b10, 0, 0));
    step("add wb",   o(0, 1, 0, 0, 0, 1, 3'b000, 0, 2'b00, 0, 0));
    exp_ret++; chk_ret("add");

    front("lw", 32'h0000A283);
    step("lw addr", o(0, 0, 0, 0, 0, 0, 3'b000, 1, 2'b00, 0, 0));
    step("lw read", o(0, 0, 0, 1, 0, 0, 3'b000, 0, 2'b00, 0, 0));
    step("lw wb",   o(0, 1, 0, 0, 0, 1, 3'b001, 0, 2'b00, 0, 0));
    exp_ret++; chk_ret("lw");

    front("sw", 32'h0050A023);
    step("sw addr",  o(0, 0, 0, 0, 0, 0, 3'b000, 1, 2'b00, 0, 0));
    step("sw write", o(0, 1, 0, 1, 1, 0, 3'b000, 0, 2'b00, 0, 0));
    exp_ret++; chk_ret("sw");

    branch_taken = 1'b1;
    front("beq t", 32'h00208063);
    step("beq t br", o(0, 1, 2'd1, 0, 0, 0, 3'b000, 0, 2'b01, 0, 0));
    exp_ret++; chk_ret("beq t wrap");
    branch_taken = 1'b0;

    front("beq nt", 32'h00208063);
    step("beq nt br", o(0, 1, 2'd0, 0, 0, 0, 3'b000, 0, 2'b01, 0, 0));
    exp_ret++; chk_ret("beq nt");

    front("jalr", 32'h000100E7);
    step("jalr", o(0, 1, 2'd2, 0, 0, 1, 3'b010, 1, 2'b00, 0, 0));
    exp_ret++; chk_ret("jalr");

    front("jal", 32'h000000EF);
    step("jal", o(0, 1, 2'd1, 0, 0, 1, 3'b010, 0, 2'b00, 0, 0));
    exp_ret++; chk_ret("jal");

    front("addi x0", 32'h00100013);
    step("addi x0 exec", o(0, 0, 0, 0, 0, 0, 3'b000, 1, 2'b10, 0, 0));
    step("addi x0 wb",   o(0, 1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0));
    exp_ret++; chk_ret("addi x0");

    front("lui", 32'h123453B7);
    step("lui", o(0, 1, 0, 0, 0, 1, 3'b011, 0, 2'b00, 0, 0));
    exp_ret++; chk_ret("lui");

    front("auipc", 32'h00000397);
    step("auipc", o(0, 1, 0, 0, 0, 1, 3'b100, 0, 2'b00, 0, 0));
    exp_ret++; chk_ret("auipc");

    // Unknown opcode: default instance halts flagged, NOP instance retires it.
    front("illegal", 32'h0000007F);
    chk("illegal halt d1", 32'(outv), 32'(o(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 1, 1)));
    chk("illegal nop d2", 32'(outv2), 32'(o(0, 1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0)));
    tick();
    chk("illegal retired", retired, 32'(exp_ret));
    chk("illegal retired2", 32'(retired2), 32'((exp_ret + 1) % 4));
    repeat (2) begin
      tick();
      chk("illegal stays", 32'(outv), 32'(o(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 1, 1)));
    end
    chk("illegal retired held", retired, 32'(exp_ret));
    do_reset();

    front("ecall", 32'h00000073);
    chk("ecall d1", 32'(outv), 32'(o(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0)));
    chk("ecall d2", 32'(outv2), 32'(o(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0)));
    tick();
    chk("ecall stays", 32'(outv), 32'(o(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0)));
    chk_ret("ecall");
    do_reset();

    front("sw rst", 32'h0050A023);
    step("sw rst addr", o(0, 0, 0, 0, 0, 0, 3'b000, 1, 2'b00, 0, 0));
    chk("sw rst write", 32'(outv), 32'(o(0, 1, 0, 1, 1, 0, 3'b000, 0, 2'b00, 0, 0)));
    resetn = 1'b0;
    tick();
    chk("sw rst dropped", 32'(outv), 32'd0);
    chk_ret("sw rst");
    resetn = 1'b1;
    chk("sw rst s_reset", 32'(outv), 32'd0);
    tick();
    chk("sw rst fetch", 32'(outv), 32'd0);
    tick();
    chk("sw rst fwait", 32'(outv), 32'(o(1, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle RV32I control unit, directly upstream of the 8:1 32-bit writeback mux.
- Sequences every instruction through fetch, decode, execute, memory and writeback states.
- Drives the mux 3-bit `option` select as `wb_sel`, together with the PC, IR, memory, register-file and ALU enables.
- Counts retired instructions and flags halt and illegal opcodes.

Parameters:
- RET_W, 32: width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1: 1 = an illegal opcode enters HALT; 0 = it retires as a NOP (PC+4).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  synchronous active-low reset.
- instr  input  32  current IR contents; opcode is [6:0], rd is [11:7].
- branch_taken  input  1  ALU compare result, valid in BRANCH.
- ir_we  output  1  IR load enable.
- pc_we  output  1  PC write enable.
- pc_sel  output  2  PC source: 0 = PC+4, 1 = PC+imm, 2 = ALU&~1, 3 = unused.
- addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
- mem_we  output  1  data memory write enable.
- reg_we  output  1  register-file write enable.
- wb_sel  output  3  writeback mux select: 000 = ALU, 001 = load data, 010 = PC+4, 011 = imm, 100 = PC+imm; 101-111 are never driven.
- alu_src_b  output  1  ALU operand B: 0 = rs2, 1 = imm.
- alu_op  output  2  ALU operation: 00 = add, 01 = branch compare, 10 = funct decode.
- halted  output  1  high while in HALT.
- illegal  output  1  high in HALT when HALT was entered on an unknown opcode.
- retired  output  RET_W  count of retired instructions.

Behaviour:
- Single clock `clk`. Reset `resetn` is synchronous, active-low.
- Reset: state=S_RESET, retired=0, illegal flag=0. Reset has priority over all transitions, including mid-instruction; any pending write is dropped.
- Outputs are decoded from the state register (Moore), with one exception: pc_sel in BRANCH depends on branch_taken.
- Unless listed for a state, every output is 0.
- S_RESET: all outputs 0; next state is FETCH.
- FETCH: addr_sel=0; next state is FETCH_WAIT. Memory read data is valid one cycle after the address.
- FETCH_WAIT: ir_we=1; next state is DECODE.
- DECODE: no enables. Next state from instr[6:0]:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 and 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - 1110011 -> HALT
  - any other opcode -> HALT with illegal latched to 1 (HALT_ON_ILLEGAL=1), or NOP_RET (HALT_ON_ILLEGAL=0).
- EXEC_R: alu_src_b=0, alu_op=10; next state is ALU_WB.
- EXEC_I: alu_src_b=1, alu_op=10; next state is ALU_WB.
- ALU_WB: reg_we, wb_sel=000, pc_we, pc_sel=0; next state is FETCH.
- MEM_ADDR: alu_src_b=1, alu_op=00. Next state is MEM_READ if instr[5]=0, else MEM_WRITE.
- MEM_READ: addr_sel=1; next state is MEM_WB.
- MEM_WB: reg_we, wb_sel=001, pc_we, pc_sel=0; next state is FETCH.
- MEM_WRITE: addr_sel=1, mem_we, pc_we, pc_sel=0; next state is FETCH.
- BRANCH: alu_op=01, pc_we, pc_sel = branch_taken ? 1 : 0; next state is FETCH.
- JAL: reg_we, wb_sel=010, pc_we, pc_sel=1; next state is FETCH.
- JALR: alu_src_b=1, alu_op=00, reg_we, wb_sel=010, pc_we, pc_sel=2; next state is FETCH.
- LUI: reg_we, wb_sel=011, pc_we, pc_sel=0; next state is FETCH.
- AUIPC: reg_we, wb_sel=100, pc_we, pc_sel=0; next state is FETCH.
- NOP_RET: pc_we, pc_sel=0; next state is FETCH.
- HALT:
  - halted=1 and all enables 0.
  - illegal=1 only if entered on an unknown opcode.
  - Stays in HALT until resetn=0.
- rd=0 (instr[11:7]=0): reg_we is forced to 0 in every state.
- Retire counter:
  - retired increments by 1 on every edge where pc_we=1.
  - Wraps from all-ones to 0 without a flag.
  - Does not count ECALL/EBREAK or illegal-opcode halts.
- Cycle counts from FETCH to the next FETCH:
  - R-type/I-type ALU: 5.
  - Load: 6.
  - Store: 5.
  - Branch, JAL, JALR, LUI, AUIPC: 4.
  - NOP_RET: 4.
- Illegal state encodings go to S_RESET on the next edge.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, release -> S_RESET for 1 cycle, then FETCH; all enables 0, retired=0.
- R-type: instr=0x002081B3 (add x3,x1,x2) -> 5 cycles; in ALU_WB, reg_we=1, wb_sel=000, pc_we=1, pc_sel=0; retired=1.
- Load then store:
  - lw x5,0(x1) (0x0000A283) -> 6 cycles; MEM_READ has addr_sel=1; MEM_WB has wb_sel=001.
  - sw (0x0050A023) -> mem_we=1 for exactly 1 cycle, reg_we never asserts.
- Branch and jump:
  - beq with branch_taken=1 -> pc_sel=1.
  - beq with branch_taken=0 -> pc_sel=0.
  - jalr x1,0(x2) -> wb_sel=010, pc_sel=2; each takes 4 cycles.
- rd=0 and LUI/AUIPC:
  - addi x0,x0,1 -> reg_we stays 0, pc_we=1.
  - lui x7,0x12345 -> wb_sel=011.
  - auipc x7 -> wb_sel=100.
- Halt and illegal:
  - opcode 0x7F -> HALT, halted=1, illegal=1, retired unchanged.
  - ecall -> halted=1, illegal=0.
  - resetn=0 during MEM_WRITE -> mem_we=0 on the next cycle, state S_RESET.
  - Force retired to all-ones (bench preload), retire one instruction -> retired=0.
